// File: rtl/channel_tap_scheduler.sv
// Symbol forwarder with a double-buffered channel tap bank. A commit flushes the
// channel history with zero symbols, then copies the shadow taps into the active bank.
module channel_tap_scheduler #(
    parameter int PULSE_RESPONSE_LENGTH = 3,
    parameter int SIGNAL_RESOLUTION     = 8
) (
    input  logic                                               clk,
    input  logic                                               rstn,
    input  logic                                               cfg_wr_valid,
    output logic                                               cfg_wr_ready,
    input  logic [7:0]                                         cfg_wr_addr,
    input  logic [2*SIGNAL_RESOLUTION-1:0]                     cfg_wr_data,
    input  logic                                               cfg_commit,
    input  logic signed [SIGNAL_RESOLUTION-1:0]                sym_in,
    input  logic                                               sym_in_valid,
    output logic                                               sym_in_ready,
    output logic signed [SIGNAL_RESOLUTION-1:0]                ch_sym_out,
    output logic                                               ch_sym_valid,
    output logic [PULSE_RESPONSE_LENGTH*2*SIGNAL_RESOLUTION-1:0] taps_active,
    output logic                                               commit_done,
    output logic                                               cfg_err
);

    localparam int TAP_W  = 2 * SIGNAL_RESOLUTION;
    localparam int BANK_W = PULSE_RESPONSE_LENGTH * TAP_W;
    localparam int CNT_W  = (PULSE_RESPONSE_LENGTH > 1) ? $clog2(PULSE_RESPONSE_LENGTH) : 1;
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(PULSE_RESPONSE_LENGTH - 1);
    // Identity response: tap0 has mantissa 1 and shift 0, every other tap is zero.
    localparam logic [BANK_W-1:0] IDENTITY = BANK_W'(1) << SIGNAL_RESOLUTION;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        SWAP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   flush_cnt;
    logic               commit_pending;
    logic [BANK_W-1:0]  shadow_bank;
    logic [BANK_W-1:0]  active_bank;
    logic               wr_fire;
    logic               wr_in_range;
    logic               sym_fire;

    assign wr_fire     = cfg_wr_valid && cfg_wr_ready;
    assign wr_in_range = int'(cfg_wr_addr) < PULSE_RESPONSE_LENGTH;
    assign sym_fire    = sym_in_valid && sym_in_ready;
    assign taps_active = active_bank;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        sym_in_ready = 1'b0;
        cfg_wr_ready = 1'b0;
        case (state)
            RUN: begin
                sym_in_ready = 1'b1;
                cfg_wr_ready = 1'b1;
                if (cfg_commit || commit_pending) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt == FLUSH_LAST) begin
                    state_next = SWAP;
                end
            end
            SWAP:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Commits arriving while a swap is in flight collapse into one pending request.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            flush_cnt      <= '0;
            commit_pending <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    flush_cnt <= '0;
                    if (state_next == FLUSH) begin
                        commit_pending <= 1'b0;
                    end
                end
                FLUSH: begin
                    flush_cnt <= (flush_cnt == FLUSH_LAST) ? '0 : flush_cnt + 1'b1;
                    if (cfg_commit) begin
                        commit_pending <= 1'b1;
                    end
                end
                default: begin
                    flush_cnt <= '0;
                    if (cfg_commit) begin
                        commit_pending <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ch_sym_out   <= '0;
            ch_sym_valid <= 1'b0;
            commit_done  <= 1'b0;
            cfg_err      <= 1'b0;
            shadow_bank  <= IDENTITY;
            active_bank  <= IDENTITY;
        end else begin
            ch_sym_out   <= '0;
            ch_sym_valid <= 1'b0;
            commit_done  <= 1'b0;
            cfg_err      <= wr_fire && !wr_in_range;
            if (wr_fire && wr_in_range) begin
                for (int i = 0; i < PULSE_RESPONSE_LENGTH; i++) begin
                    if (int'(cfg_wr_addr) == i) begin
                        shadow_bank[i*TAP_W +: TAP_W] <= cfg_wr_data;
                    end
                end
            end
            case (state)
                RUN: begin
                    if (sym_fire) begin
                        ch_sym_out   <= sym_in;
                        ch_sym_valid <= 1'b1;
                    end
                end
                FLUSH: begin
                    ch_sym_valid <= 1'b1;
                end
                SWAP: begin
                    active_bank <= shadow_bank;
                    commit_done <= 1'b1;
                end
                default: begin
                    ch_sym_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_channel_tap_scheduler.sv
// Directed bench for channel_tap_scheduler: a cycle-countdown reference model
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_channel_tap_scheduler;

    localparam int LEN = 3;
    localparam int SR  = 8;

    logic                   clk;
    logic                   rstn;
    logic                   cfg_wr_valid;
    logic                   cfg_wr_ready;
    logic [7:0]             cfg_wr_addr;
    logic [2*SR-1:0]        cfg_wr_data;
    logic                   cfg_commit;
    logic signed [SR-1:0]   sym_in;
    logic                   sym_in_valid;
    logic                   sym_in_ready;
    logic signed [SR-1:0]   ch_sym_out;
    logic                   ch_sym_valid;
    logic [LEN*2*SR-1:0]    taps_active;
    logic                   commit_done;
    logic                   cfg_err;

    int total = 0;
    int bad   = 0;

    channel_tap_scheduler #(
        .PULSE_RESPONSE_LENGTH(LEN),
        .SIGNAL_RESOLUTION(SR)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .cfg_wr_valid(cfg_wr_valid),
        .cfg_wr_ready(cfg_wr_ready),
        .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_data(cfg_wr_data),
        .cfg_commit(cfg_commit),
        .sym_in(sym_in),
        .sym_in_valid(sym_in_valid),
        .sym_in_ready(sym_in_ready),
        .ch_sym_out(ch_sym_out),
        .ch_sym_valid(ch_sym_valid),
        .taps_active(taps_active),
        .commit_done(commit_done),
        .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: blocked counts the remaining cycles in which the block refuses input.
    int                   blocked = 0;
    bit                   pend = 1'b0;
    bit                   model_live = 1'b0;
    logic [2*SR-1:0]      m_shadow [LEN];
    logic [2*SR-1:0]      m_active [LEN];
    logic                 m_valid = 1'b0;
    logic signed [SR-1:0] m_out = '0;
    logic                 m_done = 1'b0;
    logic                 m_err = 1'b0;
    logic [LEN*2*SR-1:0]  m_taps;

    always_comb begin
        m_taps = '0;
        for (int i = 0; i < LEN; i++) begin
            m_taps[i*2*SR +: 2*SR] = m_active[i];
        end
    end

    always @(posedge clk) begin
        if (!rstn) begin
            blocked = 0;
            pend    = 1'b0;
            for (int i = 0; i < LEN; i++) begin
                m_shadow[i] = (i == 0) ? 16'h0100 : 16'h0000;
                m_active[i] = (i == 0) ? 16'h0100 : 16'h0000;
            end
            m_valid = 1'b0;
            m_out   = '0;
            m_done  = 1'b0;
            m_err   = 1'b0;
        end else if (blocked == 0) begin
            m_err = cfg_wr_valid && (int'(cfg_wr_addr) >= LEN);
            for (int i = 0; i < LEN; i++) begin
                if (cfg_wr_valid && int'(cfg_wr_addr) == i) m_shadow[i] = cfg_wr_data;
            end
            m_valid = sym_in_valid;
            m_out   = sym_in_valid ? sym_in : '0;
            m_done  = 1'b0;
            if (cfg_commit || pend) begin
                blocked = LEN + 1;
                pend    = 1'b0;
            end
        end else begin
            m_err = 1'b0;
            if (cfg_commit) pend = 1'b1;
            if (blocked > 1) begin
                m_valid = 1'b1;
                m_out   = '0;
                m_done  = 1'b0;
            end else begin
                m_valid = 1'b0;
                m_out   = '0;
                m_done  = 1'b1;
                for (int i = 0; i < LEN; i++) m_active[i] = m_shadow[i];
            end
            blocked = blocked - 1;
        end
        model_live = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("sym_in_ready", 64'(sym_in_ready), 64'(blocked == 0));
            checkOutput("cfg_wr_ready", 64'(cfg_wr_ready), 64'(blocked == 0));
            checkOutput("ch_sym_valid", 64'(ch_sym_valid), 64'(m_valid));
            if (m_valid) checkOutput("ch_sym_out", 64'(ch_sym_out), 64'(m_out));
            checkOutput("commit_done", 64'(commit_done), 64'(m_done));
            checkOutput("cfg_err", 64'(cfg_err), 64'(m_err));
            checkOutput("taps_active", 64'(taps_active), 64'(m_taps));
        end
    end

    task automatic applyStimulus(input logic r, input logic sv, input logic [7:0] s,
                                 input logic wv, input logic [7:0] a, input logic [15:0] d,
                                 input logic c);
        rstn         = r;
        sym_in_valid = sv;
        sym_in       = s;
        cfg_wr_valid = wv;
        cfg_wr_addr  = a;
        cfg_wr_data  = d;
        cfg_commit   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0);
    endtask

    logic signed [7:0] stream [4] = '{-8'sd40, -8'sd8, 8'sd8, 8'sd40};
    int low_cnt;
    int zero_cnt;
    int done_cnt;

    initial begin
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0);
        checkOutput("reset_taps", 64'(taps_active), 64'h0000_0000_0100);
        checkOutput("reset_valid", 64'(ch_sym_valid), 64'd0);
        checkOutput("reset_out", 64'(ch_sym_out), 64'd0);
        checkOutput("reset_done", 64'(commit_done), 64'd0);
        checkOutput("reset_err", 64'(cfg_err), 64'd0);

        // Plain streaming with one cycle latency.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b1, stream[k], 1'b0, 8'h00, 16'h0000, 1'b0);
            checkOutput("stream_data", 64'(ch_sym_out), 64'(stream[k]));
            checkOutput("stream_valid", 64'(ch_sym_valid), 64'd1);
        end
        runIdle(1);
        checkOutput("idle_valid", 64'(ch_sym_valid), 64'd0);

        // Load shadow taps, then commit with a symbol in the same cycle.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 8'd2, 16'h0100, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 8'd1, 16'h0001, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 8'd0, 16'h0003, 1'b0);
        checkOutput("shadow_isolated", 64'(taps_active), 64'h0000_0000_0100);
        applyStimulus(1'b1, 1'b1, 8'sd17, 1'b0, 8'h00, 16'h0000, 1'b1);
        checkOutput("commit_cycle_sym", 64'(ch_sym_out), 64'd17);
        low_cnt = 0; zero_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            low_cnt += int'(!sym_in_ready);
            runIdle(1);
            zero_cnt += int'(ch_sym_valid && ch_sym_out == 0);
            done_cnt += int'(commit_done);
        end
        checkOutput("commit_ready_low", 64'(low_cnt), 64'd4);
        checkOutput("commit_zero_syms", 64'(zero_cnt), 64'd3);
        checkOutput("commit_done_cnt", 64'(done_cnt), 64'd1);
        checkOutput("commit_taps", 64'(taps_active), 64'h0100_0001_0003);

        // Second commit raised during the second flush cycle.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b1);
        runIdle(1);
        applyStimulus(1'b1, 1'b1, 8'sd5, 1'b0, 8'h00, 16'h0000, 1'b1);
        low_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            low_cnt += int'(!sym_in_ready);
            applyStimulus(1'b1, 1'b1, 8'(i + 1), 1'b0, 8'h00, 16'h0000, 1'b0);
            done_cnt += int'(commit_done);
        end
        checkOutput("pending_ready_low", 64'(low_cnt), 64'd6);
        checkOutput("pending_done_cnt", 64'(done_cnt), 64'd2);
        runIdle(1);

        // Out-of-range write is rejected and leaves both banks alone.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 8'd5, 16'hFFFF, 1'b0);
        checkOutput("bad_addr_err", 64'(cfg_err), 64'd1);
        runIdle(1);
        checkOutput("bad_addr_err_clr", 64'(cfg_err), 64'd0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b1);
        runIdle(6);
        checkOutput("bad_addr_taps", 64'(taps_active), 64'h0100_0001_0003);

        // Write and commit in the same cycle.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 8'd1, 16'h0202, 1'b1);
        runIdle(6);
        checkOutput("same_cycle_taps", 64'(taps_active), 64'h0100_0202_0003);

        // Reset in the middle of a flush aborts the swap.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 8'd0, 16'h0505, 1'b1);
        runIdle(1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0);
        checkOutput("abort_valid", 64'(ch_sym_valid), 64'd0);
        checkOutput("abort_taps", 64'(taps_active), 64'h0000_0000_0100);
        checkOutput("abort_done", 64'(commit_done), 64'd0);
        checkOutput("abort_run", 64'(sym_in_ready), 64'd1);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b1);
        runIdle(6);
        checkOutput("abort_shadow", 64'(taps_active), 64'h0000_0000_0100);

        runIdle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
